counter_array: RTL and testbench

COUNTER_ARRAY -- requirements
Module: counter_array

---
 rtl/counter_array_pkg.sv | 24 ++
 rtl/counter_channel.sv | 53 +++++
 rtl/counter_array.sv | 77 +++++++
 tb/tb_counter_array.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/counter_array_pkg.sv
// counter_array_pkg: register map, channel layout and control/status bit positions for counter_array.
package counter_array_pkg;
    localparam logic [9:0] IRQ_STATUS_ADDR = 10'h000;
    localparam logic [9:0] IRQ_MASK_ADDR   = 10'h004;
    localparam logic [9:0] CH_BASE         = 10'h100;
    localparam logic [9:0] CH_STRIDE       = 10'h010;
    localparam logic [3:0] CTRL_OFF        = 4'h0;
    localparam logic [3:0] LOAD_OFF        = 4'h4;
    localparam logic [3:0] COUNT_OFF       = 4'h8;
    localparam logic [3:0] STATUS_OFF      = 4'hC;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_SRC     = 3;
    localparam int CTRL_CLR     = 4;
    localparam int STAT_TC      = 0;
    localparam int STAT_RUN     = 1;
    typedef struct packed {
        logic src;
        logic oneshot;
        logic dir;
        logic en;
    } ctrl_t;
endpackage

// File: rtl/counter_channel.sv
// counter_channel: one up/down counter with reload, one-shot stop and sticky terminal-count flag.
module counter_channel
    import counter_array_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_evt,
    input  logic             i_ctrl_we,
    input  logic             i_load_we,
    input  logic             i_stat_we,
    input  logic [4:0]       i_ctrl,
    input  logic [CNT_W-1:0] i_load,
    input  logic             i_tc_clr,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_load,
    output ctrl_t            o_ctrl,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_count, r_load, w_next, w_clr_val;
    ctrl_t            r_ctrl;
    logic             r_tc, w_step, w_clr, w_term;

    assign w_step    = r_ctrl.en & (~r_ctrl.src | i_evt);
    assign w_clr     = i_ctrl_we & i_ctrl[CTRL_CLR];
    // CLR wins over a same-cycle step, so that edge is never a terminal step
    assign w_term    = w_step & ~w_clr & (r_ctrl.dir ? r_count == '0 : r_count == r_load);
    assign w_next    = r_ctrl.dir ? (r_count == '0 ? r_load : r_count - CNT_W'(1))
                                  : (r_count == r_load ? '0 : r_count + CNT_W'(1));
    assign w_clr_val = i_ctrl[CTRL_DIR] ? r_load : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_load  <= '1;
            r_ctrl  <= '0;
            r_tc    <= 1'b0;
        end else begin
            if (w_clr) r_count <= w_clr_val;
            else if (w_step) r_count <= w_next;
            if (i_load_we) r_load <= i_load;
            if (i_ctrl_we) r_ctrl <= ctrl_t'(i_ctrl[3:0]);
            else if (w_term && r_ctrl.oneshot) r_ctrl.en <= 1'b0;
            r_tc <= w_term | (r_tc & ~(i_stat_we & i_tc_clr));
        end
    end

    assign o_count = r_count;
    assign o_load  = r_load;
    assign o_ctrl  = r_ctrl;
    assign o_tc    = r_tc;
endmodule

// File: rtl/counter_array.sv
// counter_array: NUM_CH register-mapped counters with shared interrupt mask and registered read port.
module counter_array
    import counter_array_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [9:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [NUM_CH-1:0] evt,
    output logic              irq
);
    logic [9:0]        w_a;
    logic [NUM_CH-1:0] w_hit, w_tc, r_mask;
    logic [31:0]       w_ch_rd [NUM_CH];
    logic [31:0]       w_rd_val, r_rdata;
    logic              r_irq, w_unused;

    assign w_a      = {addr[9:2], 2'b00};
    assign w_unused = ^{addr[1:0], wdata};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [9:0] BASE = CH_BASE + 10'(g) * CH_STRIDE;
        logic [CNT_W-1:0] w_count, w_load;
        ctrl_t            w_ctrl;
        logic             w_we;
        assign w_hit[g] = w_a[9:4] == BASE[9:4];
        assign w_we     = wr_en & w_hit[g];
        counter_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_evt     (evt[g]),
            .i_ctrl_we (w_we && w_a[3:0] == CTRL_OFF),
            .i_load_we (w_we && w_a[3:0] == LOAD_OFF),
            .i_stat_we (w_we && w_a[3:0] == STATUS_OFF),
            .i_ctrl    (wdata[4:0]),
            .i_load    (wdata[CNT_W-1:0]),
            .i_tc_clr  (wdata[STAT_TC]),
            .o_count   (w_count),
            .o_load    (w_load),
            .o_ctrl    (w_ctrl),
            .o_tc      (w_tc[g])
        );
        assign w_ch_rd[g] = w_a[3:0] == CTRL_OFF  ? 32'(w_ctrl)  :
                            w_a[3:0] == LOAD_OFF  ? 32'(w_load)  :
                            w_a[3:0] == COUNT_OFF ? 32'(w_count) :
                                                    32'({w_ctrl.en, w_tc[g]});
    end

    always_comb begin
        w_rd_val = '0;
        if (w_a == IRQ_STATUS_ADDR) w_rd_val = 32'(w_tc);
        if (w_a == IRQ_MASK_ADDR) w_rd_val = 32'(r_mask);
        for (int i = 0; i < NUM_CH; i++)
            if (w_hit[i]) w_rd_val = w_ch_rd[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask  <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (wr_en && w_a == IRQ_MASK_ADDR) r_mask <= wdata[NUM_CH-1:0];
            if (rd_en) r_rdata <= w_rd_val;
            r_irq <= |(w_tc & r_mask);
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;
endmodule

// File: tb/tb_counter_array.sv
// tb_counter_array: directed table and sequence checks of counter_array with NUM_CH=4, CNT_W=3.
module tb_counter_array;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [9:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [NUM_CH-1:0] evt = '0;
    logic [31:0]       rdata;
    logic              irq;
    int                n_chk = 0, n_fail = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t vecs[$];

    counter_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .evt   (evt),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e, input string nm);
        addr = a; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        check(nm, rdata, e);
    endtask

    initial begin
        int b_exp[6] = '{3, 2, 1, 0, 3, 3};
        vecs.push_back('{1'b0, 1'b1, 10'h000, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h004, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h108, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h118, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h128, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h138, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h104, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 1'b1, 10'h114, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 1'b1, 10'h124, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 1'b1, 10'h134, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 1'b1, 10'h008, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h140, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h140, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h108, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h108, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h140, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h004, 32'hFF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h004, 32'h0, 32'hF});
        vecs.push_back('{1'b1, 1'b1, 10'h004, 32'h3, 32'hF});
        vecs.push_back('{1'b0, 1'b1, 10'h004, 32'h0, 32'h3});
        vecs.push_back('{1'b1, 1'b0, 10'h004, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h104, 32'h5, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h105, 32'h0, 32'h5});
        vecs.push_back('{1'b1, 1'b0, 10'h104, 32'h7, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h130, 32'h1E, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h130, 32'h0, 32'hE});
        vecs.push_back('{1'b0, 1'b1, 10'h138, 32'h0, 32'h7});
        vecs.push_back('{1'b0, 1'b1, 10'h13C, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h130, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h1F0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 10'h000, 32'hFF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 10'h000, 32'h0, 32'h0});

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) begin
            addr = vecs[i].a; wdata = vecs[i].d; wr_en = vecs[i].wr; rd_en = vecs[i].rd;
            cyc();
            wr_en = 1'b0; rd_en = 1'b0;
            if (vecs[i].rd) check($sformatf("vec%0d_addr%0h", i, vecs[i].a), rdata, vecs[i].e);
        end

        // TC set on the same edge as its W1C must stay set
        wr(10'h134, 32'h0);
        wr(10'h130, 32'h13);
        wr(10'h13C, 32'h1);
        rd(10'h13C, 32'h3, "ch3_tc_w1c_race");
        wr(10'h130, 32'h0);
        wr(10'h13C, 32'h1);
        rd(10'h13C, 32'h0, "ch3_tc_cleared");

        wr(10'h100, 32'h1);
        for (int k = 1; k <= 9; k++) rd(10'h108, 32'((k - 1) % 8), $sformatf("ch0_up%0d", k));
        wr(10'h100, 32'h0);
        rd(10'h10C, 32'h1, "ch0_tc_set");
        check("irq_masked", 32'(irq), 32'h0);
        wr(10'h004, 32'h1);
        check("irq_lag", 32'(irq), 32'h0);
        cyc();
        check("irq_on", 32'(irq), 32'h1);
        rd(10'h000, 32'h1, "irq_status");
        wr(10'h10C, 32'h0);
        rd(10'h10C, 32'h1, "ch0_w0_noeffect");
        wr(10'h10C, 32'h1);
        cyc();
        check("irq_off", 32'(irq), 32'h0);
        rd(10'h10C, 32'h0, "ch0_tc_clr");

        wr(10'h114, 32'h3);
        wr(10'h110, 32'h17);
        for (int k = 0; k < 6; k++) rd(10'h118, 32'(b_exp[k]), $sformatf("ch1_down%0d", k));
        rd(10'h110, 32'h6, "ch1_ctrl_en_off");
        rd(10'h11C, 32'h1, "ch1_status");

        wr(10'h120, 32'h9);
        for (int i = 0; i < 20; i++) begin
            evt[2] = (i % 4 == 1);
            cyc();
        end
        evt[2] = 1'b0;
        rd(10'h128, 32'h5, "ch2_evt_count");
        evt[2] = 1'b1;
        wr(10'h120, 32'h19);
        evt[2] = 1'b0;
        rd(10'h128, 32'h0, "ch2_clr_vs_evt");

        wr(10'h100, 32'h3);
        repeat (4) cyc();
        rd(10'h108, 32'h6, "ch0_pre_reset");
        check("irq_pre_reset", 32'(irq), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_irq_now", 32'(irq), 32'h0);
        check("rst_rdata_now", rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) cyc();
        check("post_rst_irq", 32'(irq), 32'h0);
        rd(10'h108, 32'h0, "post_rst_count");
        rd(10'h10C, 32'h0, "post_rst_status");
        rd(10'h100, 32'h0, "post_rst_ctrl");
        rd(10'h104, 32'h7, "post_rst_load");
        rd(10'h000, 32'h0, "post_rst_irq_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
